// File: rtl/clint_rd_arbiter.sv
// clint_rd_arbiter: two-master, single-slave AXI-lite read-channel arbiter that
// shares the CLINT mtime read port between instruction fetch (m0) and
// load/store (m1). One transaction is in flight at a time.
//
// Build option: define ARB_RR_EN for round-robin arbitration on ties (m0 gets
// first priority after reset). Without it, m0 always beats m1 and no history
// register exists.
module clint_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    // master 0 (instruction fetch)
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    // master 1 (load/store)
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    // slave (CLINT)
    output logic [ADDR_W-1:0] s_araddr,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rvalid,
    output logic              s_rready,
    // current owner, one-hot, zero when idle
    output logic [1:0]        grant
);

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t            r_state;
    logic [1:0]        r_grant;
    logic [ADDR_W-1:0] r_araddr;
`ifdef ARB_RR_EN
    // 1 when m1 owned the most recently completed transaction
    logic              r_last_m1;
`endif

    logic [1:0]        w_winner;
    logic              w_ar_hs;
    logic              w_r_hs;

    // Pick the winning requester among the asserted arvalids
    always_comb begin
        w_winner = GNT_NONE;
`ifdef ARB_RR_EN
        if (m0_arvalid && m1_arvalid) begin
            if (r_last_m1) begin
                w_winner = GNT_M0;
            end else begin
                w_winner = GNT_M1;
            end
        end else if (m0_arvalid) begin
            w_winner = GNT_M0;
        end else if (m1_arvalid) begin
            w_winner = GNT_M1;
        end else begin
            w_winner = GNT_NONE;
        end
`else
        if (m0_arvalid) begin
            w_winner = GNT_M0;
        end else if (m1_arvalid) begin
            w_winner = GNT_M1;
        end else begin
            w_winner = GNT_NONE;
        end
`endif
    end

    // Address acceptance: only the winner, only in IDLE, never while in reset
    always_comb begin
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        if (!rst && (r_state == ST_IDLE)) begin
            m0_arready = w_winner[0];
            m1_arready = w_winner[1];
        end else begin
            m0_arready = 1'b0;
            m1_arready = 1'b0;
        end
    end

    assign w_ar_hs = m0_arready | m1_arready;

    // Route the read-data channel between the slave and the granted master
    always_comb begin
        m0_rvalid = 1'b0;
        m0_rdata  = '0;
        m0_rresp  = 2'b00;
        m1_rvalid = 1'b0;
        m1_rdata  = '0;
        m1_rresp  = 2'b00;
        s_rready  = 1'b0;
        if (r_state == ST_DATA) begin
            case (r_grant)
                GNT_M0: begin
                    m0_rvalid = s_rvalid;
                    m0_rdata  = s_rdata;
                    m0_rresp  = s_rresp;
                    s_rready  = m0_rready;
                end
                GNT_M1: begin
                    m1_rvalid = s_rvalid;
                    m1_rdata  = s_rdata;
                    m1_rresp  = s_rresp;
                    s_rready  = m1_rready;
                end
                default: begin
                    s_rready  = 1'b0;
                end
            endcase
        end else begin
            s_rready = 1'b0;
        end
    end

    assign w_r_hs    = s_rvalid & s_rready;
    assign s_arvalid = (r_state == ST_ADDR);
    assign s_araddr  = r_araddr;
    assign grant     = r_grant;

    // Transaction sequencer: IDLE -> ADDR -> DATA -> IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_grant   <= GNT_NONE;
            r_araddr  <= '0;
`ifdef ARB_RR_EN
            r_last_m1 <= 1'b1;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_ar_hs) begin
                        r_araddr <= w_winner[0] ? m0_araddr : m1_araddr;
                        r_grant  <= w_winner;
                        r_state  <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (s_arready) begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_r_hs) begin
`ifdef ARB_RR_EN
                        r_last_m1 <= r_grant[1];
`endif
                        // address is cleared so the slave port reads 0 in IDLE
                        r_araddr <= '0;
                        r_grant  <= GNT_NONE;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_araddr <= '0;
                    r_grant  <= GNT_NONE;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clint_rd_arbiter.sv
// Scoreboard testbench for clint_rd_arbiter. Stimulus pushes expected read
// responses; a negedge monitor pops and compares on every master R handshake.
module tb_clint_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] m0_araddr = 32'h0;
    logic        m0_arvalid = 1'b0;
    logic        m0_arready;
    logic [31:0] m0_rdata;
    logic [1:0]  m0_rresp;
    logic        m0_rvalid;
    logic        m0_rready = 1'b1;
    logic [31:0] m1_araddr = 32'h0;
    logic        m1_arvalid = 1'b0;
    logic        m1_arready;
    logic [31:0] m1_rdata;
    logic [1:0]  m1_rresp;
    logic        m1_rvalid;
    logic        m1_rready = 1'b1;
    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;
    logic [1:0]  grant;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0]  who;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;
    exp_t sb[$];

    // slave model controls
    int         ar_stall = 0;
    logic [1:0] slv_resp = 2'b00;

    clint_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] slave_data(input logic [31:0] addr);
        if (addr == 32'h0200_BFF8) return 32'h0000_1234;
        return {16'hD0D0, addr[15:0]};
    endfunction

    // CLINT model: AR ready with optional stall, read data one cycle after AR
    initial begin : slave
        logic        ar_hs;
        logic        r_hs;
        logic [31:0] cap;
        s_arready = 1'b1;
        s_rvalid  = 1'b0;
        s_rdata   = 32'h0;
        s_rresp   = 2'b00;
        forever begin
            @(negedge clk);
            ar_hs = s_arvalid && s_arready;
            r_hs  = s_rvalid && s_rready;
            cap   = s_araddr;
            @(posedge clk);
            #1;
            if (rst) begin
                s_rvalid = 1'b0;
                s_rdata  = 32'h0;
                s_rresp  = 2'b00;
            end else begin
                if (r_hs) begin
                    s_rvalid = 1'b0;
                    s_rdata  = 32'h0;
                    s_rresp  = 2'b00;
                end
                if (ar_hs) begin
                    s_rvalid = 1'b1;
                    s_rdata  = slave_data(cap);
                    s_rresp  = slv_resp;
                end
            end
            if (ar_stall > 0) begin
                s_arready = 1'b0;
                ar_stall--;
            end else begin
                s_arready = 1'b1;
            end
        end
    end

    // Monitor: compare every completed read against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (m0_rvalid && m0_rready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL m0_unexpected_rsp actual=%0h required=none", m0_rdata);
                end else begin
                    e = sb.pop_front();
                    chk("m0_owner", {62'd0, grant}, {62'd0, e.who});
                    chk("m0_rdata", {32'd0, m0_rdata}, {32'd0, e.data});
                    chk("m0_rresp", {62'd0, m0_rresp}, {62'd0, e.resp});
                    chk("m1_quiet", {29'd0, m1_rvalid, m1_rdata, m1_rresp}, 64'd0);
                end
            end
            if (m1_rvalid && m1_rready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL m1_unexpected_rsp actual=%0h required=none", m1_rdata);
                end else begin
                    e = sb.pop_front();
                    chk("m1_owner", {62'd0, grant}, {62'd0, e.who});
                    chk("m1_rdata", {32'd0, m1_rdata}, {32'd0, e.data});
                    chk("m1_rresp", {62'd0, m1_rresp}, {62'd0, e.resp});
                    chk("m0_quiet", {29'd0, m0_rvalid, m0_rdata, m0_rresp}, 64'd0);
                end
            end
        end
    end

    task automatic push(input logic [1:0] who, input logic [31:0] data, input logic [1:0] resp);
        exp_t e;
        e.who  = who;
        e.data = data;
        e.resp = resp;
        sb.push_back(e);
    endtask

    task automatic wait_sb_empty(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(sb.size()), 64'd0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [1:0] exp_g;
        int n;
        // ---- reset state ----
        @(negedge clk);
        chk("rst_outputs", {30'd0, grant, s_arvalid, s_rready, m0_arready, m1_arready,
                            m0_rvalid, m1_rvalid}, 64'd0);
        chk("rst_araddr", {32'd0, s_araddr}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_quiet", {30'd0, grant, s_arvalid, s_rready, m0_arready, m1_arready,
                           m0_rvalid, m1_rvalid}, 64'd0);

        // ---- single m0 read, minimum latency ----
        m0_araddr  = 32'h0200_BFF8;
        m0_arvalid = 1'b1;
        push(2'b01, 32'h0000_1234, 2'b00);
        #1;
        chk("t1_T_m0_arready", {63'd0, m0_arready}, 64'd1);
        chk("t1_T_m1_arready", {63'd0, m1_arready}, 64'd0);
        @(posedge clk);
        #1;
        m0_arvalid = 1'b0;
        @(negedge clk);
        chk("t1_T1_s_arvalid", {63'd0, s_arvalid}, 64'd1);
        chk("t1_T1_s_araddr", {32'd0, s_araddr}, 64'h0200_BFF8);
        chk("t1_T1_grant", {62'd0, grant}, 64'd1);
        @(negedge clk);
        chk("t1_T2_m0_rvalid", {63'd0, m0_rvalid}, 64'd1);
        chk("t1_T2_grant", {62'd0, grant}, 64'd1);
        chk("t1_T2_m1_outs", {29'd0, m1_rvalid, m1_rdata, m1_rresp}, 64'd0);
        @(negedge clk);
        chk("t1_T3_grant", {62'd0, grant}, 64'd0);
        chk("t1_T3_idle", {61'd0, s_arvalid, m0_rvalid, s_rready}, 64'd0);
        chk("t1_T3_s_araddr", {32'd0, s_araddr}, 64'd0);

        // ---- both masters request continuously ----
        do_reset();
        m0_araddr  = 32'h0000_0010;
        m1_araddr  = 32'h0000_0020;
        m0_arvalid = 1'b1;
        m1_arvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b01;
`endif
            if (exp_g == 2'b01) push(2'b01, 32'hD0D0_0010, 2'b00);
            else push(2'b10, 32'hD0D0_0020, 2'b00);
        end
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b01;
`endif
            n = 0;
            while (!s_arvalid && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("t2_grant_%0d", k), {62'd0, grant}, {62'd0, exp_g});
            if (k == 3) begin
                @(posedge clk);
                #1;
                m0_arvalid = 1'b0;
                m1_arvalid = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        wait_sb_empty("t2_drain");

        // ---- slave stalls AR for 5 cycles, m1 waits ----
        ar_stall   = 5;
        m0_araddr  = 32'h0000_0030;
        m1_araddr  = 32'h0000_0040;
        m0_arvalid = 1'b1;
        m1_arvalid = 1'b1;
        push(2'b01, 32'hD0D0_0030, 2'b00);
        push(2'b10, 32'hD0D0_0040, 2'b00);
        #1;
        chk("t3_m0_arready", {62'd0, m0_arready, m1_arready}, 64'd2);
        @(posedge clk);
        #1;
        m0_arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("t3_hold_%0d", i), {1'b0, s_arvalid, m1_arready, grant, 27'd0, s_araddr},
                {1'b0, 1'b1, 1'b0, 2'b01, 27'd0, 32'h0000_0030});
        end
        @(negedge clk);
        @(negedge clk);
        chk("t3_m0_data", {62'd0, m0_rvalid, m1_arready}, 64'd2);
        @(negedge clk);
        chk("t3_m1_accept", {61'd0, m1_arready, grant}, 64'd4);

        // ---- m1 holds rready low for 3 cycles ----
        @(posedge clk);
        #1;
        m1_arvalid = 1'b0;
        m1_rready  = 1'b0;
        @(negedge clk);
        chk("t4_addr", {30'd0, grant, s_araddr}, {30'd0, 2'b10, 32'h0000_0040});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("t4_stall_%0d", i), {29'd0, m1_rvalid, s_rready, grant, m0_rvalid},
                {29'd0, 1'b1, 1'b0, 2'b10, 1'b0});
            chk($sformatf("t4_stall_data_%0d", i), {32'd0, m1_rdata}, 64'hD0D0_0040);
        end
        @(posedge clk);
        #1;
        m1_rready = 1'b1;
        @(negedge clk);
        chk("t4_release", {63'd0, s_rready}, 64'd1);
        @(negedge clk);
        chk("t4_idle_grant", {62'd0, grant}, 64'd0);
        wait_sb_empty("t34_drain");

        // ---- SLVERR passes through unchanged ----
        slv_resp   = 2'b10;
        m1_araddr  = 32'h0000_0050;
        m1_arvalid = 1'b1;
        push(2'b10, 32'hD0D0_0050, 2'b10);
        @(posedge clk);
        #1;
        m1_arvalid = 1'b0;
        wait_sb_empty("t5_drain");
        slv_resp = 2'b00;

        // ---- async reset during DATA ----
        m0_rready  = 1'b0;
        m0_araddr  = 32'h0000_0060;
        m0_arvalid = 1'b1;
        @(posedge clk);
        #1;
        m0_arvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t6_in_data", {62'd0, m0_rvalid, s_rready}, 64'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_outs", {28'd0, grant, s_arvalid, s_rready, m0_arready, m1_arready,
                              m0_rvalid, m1_rvalid, m0_rresp, m1_rresp}, 64'd0);
        chk("t6_async_araddr", {32'd0, s_araddr}, 64'd0);
        chk("t6_async_rdata", {m0_rdata, m1_rdata}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst       = 1'b0;
        m0_rready = 1'b1;
        m1_araddr = 32'h0000_0070;
        m1_arvalid = 1'b1;
        push(2'b10, 32'hD0D0_0070, 2'b00);
        #1;
        chk("t6_post_accept", {62'd0, m0_arready, m1_arready}, 64'd1);
        @(posedge clk);
        #1;
        m1_arvalid = 1'b0;
        @(negedge clk);
        chk("t6_post_addr", {29'd0, s_arvalid, grant, s_araddr}, {29'd0, 1'b1, 2'b10, 32'h0000_0070});
        @(negedge clk);
        chk("t6_post_rvalid", {62'd0, m1_rvalid, m0_rvalid}, 64'd2);
        @(negedge clk);
        chk("t6_post_idle", {62'd0, grant}, 64'd0);
        wait_sb_empty("final_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clint_rd_arbiter.md
Name: clint_rd_arbiter

Overview:
- Two-master, single-slave AXI-lite read-channel arbiter that shares the CLINT mtime read port between the instruction-fetch side (m0) and the load/store side (m1).
- Sits between the two requesters and the CLINT.
- Serialises requests: exactly one outstanding transaction at a time, address registered toward the slave, read data/response forwarded back to the granted master.

Parameters:
ADDR_W, 32, width of araddr on all ports
DATA_W, 32, width of rdata on all ports

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
m0_araddr / m1_araddr  input  ADDR_W  master read address
m0_arvalid / m1_arvalid  input  1  master read-address valid
m0_arready / m1_arready  output  1  address accepted from that master
m0_rdata / m1_rdata  output  DATA_W  read data returned to that master
m0_rresp / m1_rresp  output  2  read response returned to that master
m0_rvalid / m1_rvalid  output  1  read data valid to that master
m0_rready / m1_rready  input  1  master ready for read data
s_araddr  output  ADDR_W  registered address to CLINT
s_arvalid  output  1  address valid to CLINT
s_arready  input  1  CLINT address ready
s_rdata  input  DATA_W  CLINT read data
s_rresp  input  2  CLINT response (OKAY = 2'b00)
s_rvalid  input  1  CLINT data valid
s_rready  output  1  ready toward CLINT
grant  output  2  one-hot owner of current transaction (bit0 = m0, bit1 = m1), 0 when idle

Behaviour:
- FSM states IDLE, ADDR, DATA. Reset (async, rst=1) forces IDLE, grant=0, s_araddr=0, last_grant=m1.
- All outputs are 0 during reset and in IDLE, except mX_arready as defined below.
- Reset mid-transaction aborts it; no response is delivered.
- IDLE:
  - Winner chosen combinationally among asserted mX_arvalid.
  - mX_arready=1 only for the winner, same cycle.
  - On that handshake: s_araddr <= mX_araddr, grant <= winner, next state ADDR.
  - No request: stay in IDLE.
- ADDR:
  - s_arvalid=1 with registered s_araddr.
  - s_araddr and grant are held stable until s_arready.
  - On s_arvalid && s_arready: go to DATA.
- DATA:
  - s_rready = granted master's mX_rready.
  - Granted master receives mX_rvalid=s_rvalid, mX_rdata=s_rdata, mX_rresp=s_rresp, passed through unmodified (incl. SLVERR/DECERR).
  - Non-granted master sees rvalid=0, rdata=0, rresp=0.
  - On s_rvalid && s_rready: last_grant <= grant, grant <= 0, go to IDLE.
- mX_arready is 0 in ADDR and DATA; a new request waits until IDLE.
- Minimum transaction latency with an always-ready slave: AR accept at cycle T, s_arvalid at T+1, rvalid to master at T+2, back in IDLE at T+3.
- Throughput: one transaction per 3 cycles.
- Simultaneous m0/m1 requests in IDLE are resolved by the arbitration policy; the loser keeps arvalid asserted and is served next.
- A master dropping arvalid before its grant is legal; it is simply not served.
- Granted master holding rready=0 stalls the arbiter in DATA indefinitely (no timeout).

Optional Feature:
ARB_RR_EN
- Defined: round-robin. On a tie the master not equal to last_grant wins; a single requester always wins. After reset m0 has first priority (last_grant=m1).
- Undefined: fixed priority, m0 always beats m1; last_grant register is omitted.

Test Plan:
- Single m0 read of addr 0x0200_BFF8 with always-ready slave returning 0x0000_1234 -> m0_arready at T, s_arvalid/s_araddr=0x0200_BFF8 at T+1, m0_rvalid with rdata 0x0000_1234 and rresp=00 at T+2, grant=01 through T+2, grant=00 at T+3; m1 outputs stay 0.
- m0 and m1 both request continuously for 4 transactions -> without ARB_RR_EN grant sequence 01,01,01,01; with ARB_RR_EN 01,10,01,10.
- Slave holds s_arready=0 for 5 cycles -> s_arvalid and s_araddr stay constant; m1_arvalid=1 during this gets arready=0; m1 is accepted in the first IDLE cycle after m0 completes.
- m1 granted, m1_rready=0 for 3 cycles while s_rvalid=1 -> s_rready=0, FSM stays in DATA, m1_rvalid=1; completes on the cycle m1_rready=1.
- Slave returns rresp=2'b10 -> granted master sees rresp=10 unchanged.
- rst asserted asynchronously during DATA -> all outputs 0 without a clock edge, grant=00; first request after deassertion handled normally from IDLE.
